fp_div: RTL

- Iterative IEEE-754 single-precision divider (result = a / b). It is the inverse-operation companion to the pipelined floating-point multiplier in the VLIW execution cluster.
- Inputs arrive and results leave over valid/ready handshakes.
- Only one operation is in flight at a time.
- Mantissa quotient is produced by restoring division, 1 bit per cycle. Result is truncated (round-toward-zero), matching the multiplier's truncation.

---
 rtl/fp_div_pkg.sv | 40 ++++
 rtl/fp_div_if.sv | 21 ++
 rtl/fp_div_mant_core.sv | 61 ++++++
 rtl/fp_div.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the single-precision divider.
package fp_pkg;

    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp_state_e;

    // Denormals (exponent 0) are flushed to zero.
    function automatic fp_class_e classify(input logic [7:0] exp_f, input logic [22:0] man_f);
        fp_class_e cls;
        if (exp_f == 8'hFF) begin
            if (man_f != 23'd0) begin
                cls = FP_NAN;
            end else begin
                cls = FP_INF;
            end
        end else if (exp_f == 8'h00) begin
            cls = FP_ZERO;
        end else begin
            cls = FP_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for fp_div.
interface fp_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/fp_div_mant_core.sv
// 24-bit restoring divider producing a 25-bit quotient, one bit per cycle.
// done is high during the final iteration; quotient is complete after that edge.
module fp_div_mant_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [24:0] quotient
);
    logic [24:0] r_rem;
    logic [23:0] r_div;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic        w_ge;
    logic [23:0] w_diff;

    // After a successful subtract the remainder is below the divisor, so 24 bits suffice.
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = r_rem[23:0] - r_div;

    // One quotient bit per cycle, MSB (bit 24) first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 25'd0;
            r_div  <= 24'd0;
            r_q    <= 25'd0;
            r_cnt  <= 5'd0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= {1'b0, dividend};
            r_div  <= divisor;
            r_q    <= 25'd0;
            r_cnt  <= 5'd24;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_ge) begin
                r_rem <= {w_diff, 1'b0};
                r_q   <= r_q | (25'd1 << r_cnt);
            end else begin
                r_rem <= {r_rem[23:0], 1'b0};
            end
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd0) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else begin
            r_busy <= 1'b0;
        end
    end

    assign busy     = r_busy;
    assign done     = r_busy && (r_cnt == 5'd0);
    assign quotient = r_q;
endmodule

// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider, truncating, one op in flight.
module fp_div
    import fp_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst_n,
    fp_div_if.slave  bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DIV  = DIV;
    localparam logic [1:0] S_NORM = NORM;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic signed [9:0] BIAS_HI = 10'(EXP_BIAS);
    localparam logic signed [9:0] BIAS_LO = 10'(EXP_BIAS - 1);

    logic [1:0]  r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_dbz;
    logic        r_sign;
    logic [7:0]  r_exp_a;
    logic [7:0]  r_exp_b;
    logic        r_special;
    logic [31:0] r_spec_res;
    logic        r_spec_dbz;

    fp_class_e   w_cls_a;
    fp_class_e   w_cls_b;
    logic        w_sign;
    logic        w_accept;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic        w_spec_dbz;
    logic        w_core_busy;
    logic        w_core_done;
    logic [24:0] w_quot;
    logic signed [9:0] w_e;
    logic [22:0] w_mant;
    logic [31:0] w_norm_res;
    logic        w_norm_dbz;

    assign w_cls_a  = classify(bus.a[30:23], bus.a[22:0]);
    assign w_cls_b  = classify(bus.b[30:23], bus.b[22:0]);
    assign w_sign   = bus.a[31] ^ bus.b[31];
    assign w_accept = bus.in_valid && r_in_ready;

    // Decide at accept whether the operand classes bypass the mantissa divider.
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = 32'd0;
        w_spec_dbz = 1'b0;
        if ((w_cls_a == FP_NAN) || (w_cls_b == FP_NAN)) begin
            w_spec_res = NAN_VALUE;
        end else begin
            case (w_cls_a)
                FP_ZERO: begin
                    if (w_cls_b == FP_ZERO) begin
                        w_spec_res = NAN_VALUE;
                    end else begin
                        w_spec_res = {w_sign, 31'd0};
                    end
                end
                FP_INF: begin
                    if (w_cls_b == FP_INF) begin
                        w_spec_res = NAN_VALUE;
                    end else begin
                        w_spec_res = w_sign ? FP_NEG_INF : FP_POS_INF;
                    end
                end
                FP_NORM: begin
                    case (w_cls_b)
                        FP_ZERO: begin
                            w_spec_res = w_sign ? FP_NEG_INF : FP_POS_INF;
                            w_spec_dbz = 1'b1;
                        end
                        FP_INF:  w_spec_res = {w_sign, 31'd0};
                        default: w_special  = 1'b0;
                    endcase
                end
                default: w_spec_res = NAN_VALUE;
            endcase
        end
    end

    fp_div_mant_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_accept && !w_special),
        .dividend ({1'b1, bus.a[22:0]}),
        .divisor  ({1'b1, bus.b[22:0]}),
        .busy     (w_core_busy),
        .done     (w_core_done),
        .quotient (w_quot)
    );

    assign w_e    = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b})
                  + (w_quot[24] ? BIAS_HI : BIAS_LO);
    assign w_mant = w_quot[24] ? w_quot[23:1] : w_quot[22:0];

    // Normalise the quotient and clamp the exponent, or pass a special result through.
    always_comb begin
        w_norm_res = 32'd0;
        w_norm_dbz = 1'b0;
        if (r_special) begin
            w_norm_res = r_spec_res;
            w_norm_dbz = r_spec_dbz;
        end else if (w_e >= 10'sd255) begin
            w_norm_res = r_sign ? FP_NEG_INF : FP_POS_INF;
        end else if (w_e <= 10'sd0) begin
            w_norm_res = {r_sign, 31'd0};
        end else begin
            w_norm_res = {r_sign, w_e[7:0], w_mant};
        end
    end

    // Control FSM; special cases take the NORM stage too, giving a one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_dbz       <= 1'b0;
            r_sign      <= 1'b0;
            r_exp_a     <= 8'd0;
            r_exp_b     <= 8'd0;
            r_special   <= 1'b0;
            r_spec_res  <= 32'd0;
            r_spec_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign     <= w_sign;
                        r_exp_a    <= bus.a[30:23];
                        r_exp_b    <= bus.b[30:23];
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_spec_dbz <= w_spec_dbz;
                        r_in_ready <= 1'b0;
                        r_state    <= w_special ? S_NORM : S_DIV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (w_core_done) begin
                        r_state <= S_NORM;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_NORM: begin
                    r_result    <= w_norm_res;
                    r_dbz       <= w_norm_dbz;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

    logic w_unused;
    assign w_unused = w_core_busy;
endmodule
